// File: rtl/debug_jtag_scan_master_pkg.sv
// debug_jtag_scan_master_pkg: shared state encoding and default widths for the JTAG scan master.
package debug_jtag_scan_master_pkg;
    localparam int DR_W_DEF = 38;
    localparam int IR_W_DEF = 2;
    typedef enum logic [2:0] {
        S_IDLE,
        S_UIR,
        S_CDR,
        S_SDR,
        S_UDR,
        S_RTI,
        S_RESP
    } state_t;
endpackage

// File: rtl/debug_jtag_scan_master_if.sv
// debug_jtag_scan_master_if: command/response handshake plus virtual JTAG slave signals.
interface debug_jtag_scan_master_if import debug_jtag_scan_master_pkg::*; #(
    parameter int DR_W = DR_W_DEF,
    parameter int IR_W = IR_W_DEF
) ();
    logic            cmd_valid;
    logic            cmd_ready;
    logic [IR_W-1:0] cmd_ir;
    logic [DR_W-1:0] cmd_dr;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DR_W-1:0] rsp_dr;
    logic [IR_W-1:0] rsp_ir_out;
    logic            vji_tck;
    logic            vji_tdi;
    logic            vji_tdo;
    logic [IR_W-1:0] vji_ir_in;
    logic [IR_W-1:0] vji_ir_out;
    logic            vji_uir;
    logic            vji_cdr;
    logic            vji_sdr;
    logic            vji_udr;
    logic            vji_rti;

    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );
    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );
endinterface

// File: rtl/debug_jtag_scan_master_tck_gen.sv
// debug_jtag_tck_gen: TCK divider; counter rests at zero while idle so every state starts on a fresh period.
module debug_jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_tck,
    output logic o_period_start,
    output logic o_tck_rise,
    output logic o_period_end
);
    localparam int CW = $clog2(2 * TCK_DIV);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || !i_run || o_period_end)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tck          = i_run && r_cnt >= CW'(TCK_DIV);
    assign o_period_start = i_run && r_cnt == '0;
    assign o_tck_rise     = i_run && r_cnt == CW'(TCK_DIV);
    assign o_period_end   = i_run && r_cnt == CW'(2 * TCK_DIV - 1);
endmodule

// File: rtl/debug_jtag_scan_master.sv
// debug_jtag_scan_master: runs one UIR-CDR-SDR-UDR-RTI virtual JTAG scan per command and returns captured TDO.
module debug_jtag_scan_master import debug_jtag_scan_master_pkg::*; #(
    parameter int DR_W    = DR_W_DEF,
    parameter int IR_W    = IR_W_DEF,
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    debug_jtag_scan_master_if.master bus
);
    localparam int BW = $clog2(DR_W + 1);

    state_t          r_state, w_next;
    logic [IR_W-1:0] r_ir, r_ir_out;
    logic [DR_W-1:0] r_tx, r_cap;
    logic [BW-1:0]   r_bits;
    logic            w_run, w_tck, w_pstart, w_rise, w_pend, w_sdr, w_resp;

    assign w_run  = r_state inside {S_UIR, S_CDR, S_SDR, S_UDR, S_RTI};
    assign w_sdr  = r_state == S_SDR;
    assign w_resp = r_state == S_RESP;

    debug_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
        .clk            (clk),
        .reset          (reset),
        .i_run          (w_run),
        .o_tck          (w_tck),
        .o_period_start (w_pstart),
        .o_tck_rise     (w_rise),
        .o_period_end   (w_pend)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: w_next = bus.cmd_valid ? S_UIR : S_IDLE;
            S_UIR:  w_next = w_pend ? S_CDR : S_UIR;
            S_CDR:  w_next = w_pend ? S_SDR : S_CDR;
            S_SDR:  w_next = (w_pend && r_bits == BW'(DR_W)) ? S_UDR : S_SDR;
            S_UDR:  w_next = w_pend ? S_RTI : S_UDR;
            S_RTI:  w_next = w_pend ? S_RESP : S_RTI;
            S_RESP: w_next = bus.rsp_ready ? S_IDLE : S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // TDI advances at period end so the new bit is stable from the next period start; TDO enters at the MSB
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir     <= '0;
            r_tx     <= '0;
            r_cap    <= '0;
            r_ir_out <= '0;
            r_bits   <= '0;
        end else begin
            if (r_state == S_IDLE && bus.cmd_valid) begin
                r_ir <= bus.cmd_ir;
                r_tx <= bus.cmd_dr;
            end
            if (w_sdr && w_pend)
                r_tx <= r_tx >> 1;
            if (w_sdr && w_rise)
                r_cap <= DR_W'({bus.vji_tdo, r_cap} >> 1);
            if (r_state == S_CDR && w_rise)
                r_ir_out <= bus.vji_ir_out;
            r_bits <= !w_sdr ? '0 : w_pstart ? r_bits + 1'b1 : r_bits;
        end
    end

    assign bus.cmd_ready  = r_state == S_IDLE;
    assign bus.rsp_valid  = w_resp;
    assign bus.rsp_dr     = w_resp ? r_cap : '0;
    assign bus.rsp_ir_out = w_resp ? r_ir_out : '0;
    assign bus.vji_tck    = w_tck;
    assign bus.vji_tdi    = w_sdr ? r_tx[0] : 1'b0;
    assign bus.vji_ir_in  = w_run ? r_ir : '0;
    assign bus.vji_uir    = r_state == S_UIR;
    assign bus.vji_cdr    = r_state == S_CDR;
    assign bus.vji_sdr    = w_sdr;
    assign bus.vji_udr    = r_state == S_UDR;
    assign bus.vji_rti    = r_state == S_RTI;
endmodule

// File: tb/tb_debug_jtag_scan_master.sv
// tb_debug_jtag_scan_master: directed vector table plus corner-case sequences for the scan master.
module tb_debug_jtag_scan_master;
    import debug_jtag_scan_master_pkg::*;

    localparam int DW = 38;
    localparam int IW = 2;
    localparam int ORDER_EXP = 'o12345;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] tdo_mode = 2'd0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    debug_jtag_scan_master_if #(.DR_W(DW), .IR_W(IW)) b0 ();
    debug_jtag_scan_master_if #(.DR_W(4),  .IR_W(IW)) b1 ();

    // slave model: loopback, TDO tied high, or TDO tied low
    assign b0.vji_tdo = (tdo_mode == 2'd0) ? b0.vji_tdi : (tdo_mode == 2'd1);
    assign b1.vji_tdo = b1.vji_tdi;

    debug_jtag_scan_master #(.DR_W(DW), .IR_W(IW), .TCK_DIV(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (b0.master)
    );
    debug_jtag_scan_master #(.DR_W(4), .IR_W(IW), .TCK_DIV(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.master)
    );

    typedef struct {
        logic [IW-1:0] ir;
        logic [DW-1:0] dr;
        logic [1:0]    mode;
        logic [IW-1:0] ir_out;
        logic [DW-1:0] exp_dr;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int strobe_id(input logic u, c, s, d, r);
        return u ? 1 : c ? 2 : s ? 3 : d ? 4 : r ? 5 : 0;
    endfunction

    task automatic scan0(input vec_t v);
        int n = 0, tck_err = 0, ir_err = 0, oh_err = 0, sdr_cyc = 0, order = 0, prev = 0, id;
        tdo_mode = v.mode;
        b0.vji_ir_out = v.ir_out;
        b0.cmd_ir = v.ir;
        b0.cmd_dr = v.dr;
        chk("ready_before_scan", 64'(b0.cmd_ready), 64'd1);
        b0.cmd_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            n++;
            if (n == 1) b0.cmd_valid = 1'b0;
            if (b0.rsp_valid || n >= 400) break;
            if (b0.vji_tck !== (((n - 1) % 4) >= 2)) tck_err++;
            if (b0.vji_ir_in !== v.ir) ir_err++;
            if ($countones({b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr, b0.vji_rti}) != 1) oh_err++;
            if (b0.vji_sdr) sdr_cyc++;
            id = strobe_id(b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr, b0.vji_rti);
            if (id != 0 && id != prev) order = order * 8 + id;
            prev = id;
        end
        chk("rsp_latency", 64'(n), 64'd169);
        chk("rsp_dr", 64'(b0.rsp_dr), 64'(v.exp_dr));
        chk("rsp_ir_out", 64'(b0.rsp_ir_out), 64'(v.ir_out));
        chk("tck_pattern_errs", 64'(tck_err), 64'd0);
        chk("ir_in_errs", 64'(ir_err), 64'd0);
        chk("strobe_onehot_errs", 64'(oh_err), 64'd0);
        chk("strobe_order", 64'(order), 64'(ORDER_EXP));
        chk("sdr_cycles", 64'(sdr_cyc), 64'd152);
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.rsp_ready = 1'b0;
        chk("back_to_idle_ready", 64'(b0.cmd_ready), 64'd1);
    endtask

    initial begin
        int n, err_stable, err_ready, err_rsp;
        b0.cmd_valid = 1'b0; b0.cmd_ir = '0; b0.cmd_dr = '0; b0.rsp_ready = 1'b0; b0.vji_ir_out = '0;
        b1.cmd_valid = 1'b0; b1.cmd_ir = '0; b1.cmd_dr = '0; b1.rsp_ready = 1'b0; b1.vji_ir_out = '0;

        vt[0] = '{ir: 2'b01, dr: 38'h2A_5555_AAAA, mode: 2'd0, ir_out: 2'b11, exp_dr: 38'h2A_5555_AAAA};
        vt[1] = '{ir: 2'b11, dr: 38'h00_0000_0000, mode: 2'd1, ir_out: 2'b10, exp_dr: 38'h3F_FFFF_FFFF};
        vt[2] = '{ir: 2'b10, dr: 38'h01_2345_6789, mode: 2'd0, ir_out: 2'b01, exp_dr: 38'h01_2345_6789};
        vt[3] = '{ir: 2'b01, dr: 38'h3F_FFFF_FFFF, mode: 2'd2, ir_out: 2'b00, exp_dr: 38'h00_0000_0000};

        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(b0.cmd_ready), 64'd1);
        chk("reset_outputs", 64'({b0.rsp_valid, b0.rsp_dr, b0.rsp_ir_out, b0.vji_tck, b0.vji_tdi,
            b0.vji_ir_in, b0.vji_uir, b0.vji_cdr, b0.vji_sdr, b0.vji_udr, b0.vji_rti}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) scan0(vt[i]);

        // response held off with a new command waiting
        tdo_mode = 2'd0;
        b0.cmd_ir = 2'b01;
        b0.cmd_dr = 38'h2A_5555_AAAA;
        b0.vji_ir_out = 2'b10;
        b0.cmd_valid = 1'b1;
        n = 0;
        while (!b0.rsp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rsp_latency", 64'(n), 64'd169);
        err_stable = 0;
        err_ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!b0.rsp_valid || b0.rsp_dr !== 38'h2A_5555_AAAA || b0.rsp_ir_out !== 2'b10) err_stable++;
            if (b0.cmd_ready !== 1'b0) err_ready++;
        end
        chk("hold_rsp_stable_errs", 64'(err_stable), 64'd0);
        chk("hold_cmd_ready_errs", 64'(err_ready), 64'd0);
        b0.rsp_ready = 1'b1;
        @(negedge clk);
        b0.rsp_ready = 1'b0;
        chk("idle_cycle_ready", 64'(b0.cmd_ready), 64'd1);
        chk("idle_cycle_rsp_valid", 64'(b0.rsp_valid), 64'd0);
        @(negedge clk);
        b0.cmd_valid = 1'b0;
        chk("reaccept_uir", 64'(b0.vji_uir), 64'd1);

        // abort inside the 10th SDR period
        n = 0;
        while (!b0.vji_sdr && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_sdr", 64'(b0.vji_sdr), 64'd1);
        repeat (37) @(negedge clk);
        chk("in_sdr_before_abort", 64'(b0.vji_sdr), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_vji_zero", 64'({b0.vji_tck, b0.vji_tdi, b0.vji_ir_in, b0.vji_uir, b0.vji_cdr,
            b0.vji_sdr, b0.vji_udr, b0.vji_rti}), 64'd0);
        chk("abort_ready", 64'(b0.cmd_ready), 64'd1);
        err_rsp = 0;
        for (int i = 0; i < 200; i++) begin
            if (b0.rsp_valid !== 1'b0) err_rsp++;
            @(negedge clk);
        end
        chk("abort_no_rsp", 64'(err_rsp), 64'd0);

        // fastest divider, short register
        b1.cmd_ir = 2'b01;
        b1.cmd_dr = 4'b1001;
        b1.vji_ir_out = 2'b10;
        b1.cmd_valid = 1'b1;
        n = 0;
        err_stable = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (n == 1) b1.cmd_valid = 1'b0;
            if (b1.rsp_valid || n >= 100) break;
            if (b1.vji_tck !== ((n - 1) % 2 == 1)) err_stable++;
        end
        chk("div1_latency", 64'(n), 64'd17);
        chk("div1_tck_toggle_errs", 64'(err_stable), 64'd0);
        chk("div1_rsp_dr", 64'(b1.rsp_dr), 64'(4'b1001));
        chk("div1_rsp_ir_out", 64'(b1.rsp_ir_out), 64'(2'b10));
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        chk("div1_idle", 64'(b1.cmd_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/debug_jtag_scan_master.md
DEBUG_JTAG_SCAN_MASTER -- requirements
Module: debug_jtag_scan_master

Interface
REQ-001 Parameter DR_W, default 38, debug data-register scan length in bits.
REQ-002 Parameter IR_W, default 2, virtual instruction register width.
REQ-003 Parameter TCK_DIV, default 2, TCK half-period in clk cycles; legal values are 1 or more.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all logic rises on it.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  scan request.
REQ-008 cmd_ready  out  1  block idle and able to accept a request.
REQ-009 cmd_ir  in  IR_W  instruction value for the scan.
REQ-010 cmd_dr  in  DR_W  data value to shift in, LSB first.
REQ-011 rsp_valid  out  1  scan result available.
REQ-012 rsp_ready  in  1  consumer accepts the result.
REQ-013 rsp_dr  out  DR_W  captured TDO bits; bit 0 is the first bit sampled.
REQ-014 rsp_ir_out  out  IR_W  ir_out value sampled during the capture state.
REQ-015 vji_tck, vji_tdi  out  1 each  TCK and TDI driven to the debug slave.
REQ-016 vji_ir_in  out  IR_W  instruction presented to the slave.
REQ-017 vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual-state strobes.
REQ-018 vji_tdo  in  1  TDO from the slave; vji_ir_out  in  IR_W  IR readback from the slave.

Function
REQ-019 The FSM SHALL have the states IDLE, UIR, CDR, SDR, UDR, RTI and RESP.
REQ-020 A handshake SHALL occur when cmd_valid and cmd_ready are both high. On handshake, cmd_ir and cmd_dr SHALL be latched and the FSM SHALL enter UIR on the next cycle.
REQ-021 cmd_ready SHALL be high only in IDLE; requests presented while busy SHALL be held off and not dropped.
REQ-022 Every non-IDLE/RESP state SHALL last whole TCK periods of 2*TCK_DIV clk cycles: UIR, CDR, UDR and RTI last 1 period each; SDR lasts DR_W periods.
REQ-023 Within each TCK period, vji_tck SHALL be low for the first TCK_DIV cycles and high for the last TCK_DIV cycles; vji_tck SHALL be 0 in IDLE and RESP.
REQ-024 Each state's strobe SHALL be high for that state's entire duration, and at most one strobe SHALL be high in any cycle.
REQ-025 vji_ir_in SHALL carry the latched cmd_ir from UIR through RTI, and SHALL be 0 otherwise.
REQ-026 vji_tdi SHALL update at the start of each SDR TCK period, shifting the latched data LSB first; vji_tdi SHALL be 0 outside SDR.
REQ-027 vji_tdo SHALL be sampled on the clk cycle where vji_tck rises in SDR; the sample SHALL shift into the shift-register MSB, so bit 0 is the earliest sample after DR_W shifts.
REQ-028 vji_ir_out SHALL be sampled into rsp_ir_out on the TCK rising cycle of CDR.
REQ-029 Latency: with handshake in cycle T, rsp_valid SHALL first assert in cycle T+1+(DR_W+4)*2*TCK_DIV; for defaults that is T+169.
REQ-030 In RESP, rsp_valid SHALL stay high, and rsp_dr and rsp_ir_out SHALL stay stable, until rsp_ready is seen; the FSM SHALL then return to IDLE on the next cycle.
REQ-031 cmd_valid held high during RESP SHALL NOT be accepted before the IDLE cycle.
REQ-032 The bit counter SHALL be $clog2(DR_W+1) bits wide and SHALL leave SDR exactly when DR_W bits have been shifted; no wrap-around beyond DR_W.
REQ-033 When TCK_DIV=1, the period SHALL be exactly 2 clk cycles with no idle cycles between states.

Reset
REQ-034 In the cycle after reset is sampled high, the FSM SHALL be in IDLE, cmd_ready SHALL be 1, and all other outputs (rsp_*, vji_*) SHALL be 0.
REQ-035 A reset asserted mid-scan SHALL abort the scan with no response, and all strobes SHALL be low in the cycle after reset is sampled.

Structure
REQ-036 A shared package SHALL hold the state enum and the DR_W and IR_W defaults.
REQ-037 One sub-module, debug_jtag_tck_gen, SHALL provide the divide counter, vji_tck, and one-cycle period_start, tck_rise and period_end pulses.

Verification
REQ-038 Default parameters, cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA, slave loopback tdo=tdi -> rsp_dr=38'h2A_5555_AAAA, rsp_valid at T+169.
REQ-039 vji_tdo tied to 1, vji_ir_out=2'b10 -> rsp_dr all ones, rsp_ir_out=2'b10; strobe order uir,cdr,sdr(152 cycles),udr,rti.
REQ-040 rsp_ready held low for 20 cycles after rsp_valid, with cmd_valid high -> rsp stable, cmd_ready 0, next accept only after the IDLE cycle.
REQ-041 Reset pulsed in the 10th SDR period -> next cycle all vji_* 0, cmd_ready 1, no rsp_valid.
REQ-042 TCK_DIV=1, DR_W=4, cmd_dr=4'b1001 with loopback -> vji_tck toggles every cycle, rsp_dr=4'b1001 at T+17.
